// File: rtl/sd_crc_pkg.sv
// sd_crc_pkg: shared state type, SD CRC polynomials and lane slicing helper
// for the multi-lane CRC engine.
package sd_crc_pkg;
    typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} crc_state_t;
    localparam logic [7:0]  CRC7_GEN  = 8'h89;
    localparam logic [16:0] CRC16_GEN = 17'h11021;
    function automatic int lane_lsb(input int lane, input int len);
        return lane * len;
    endfunction
endpackage

// File: rtl/crc_lane_lfsr.sv
// crc_lane_lfsr: single-lane MSB-first CRC shift register with load and step
// controls; o_next exposes the value the register takes on the next edge.
module crc_lane_lfsr #(
    parameter int LEN = 16,
    parameter logic [LEN-1:0] POLY = 16'h1021,
    parameter logic [LEN-1:0] INIT = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_bit,
    output logic [LEN-1:0] o_crc,
    output logic [LEN-1:0] o_next
);
    logic [LEN-1:0] r_crc;
    logic           w_inv;
    always_comb begin
        w_inv  = i_bit ^ r_crc[LEN-1];
        o_next = i_load ? INIT
               : i_step ? {r_crc[LEN-2:0], 1'b0} ^ ({LEN{w_inv}} & POLY)
               : r_crc;
        o_crc  = r_crc;
    end
    always_ff @(posedge clk) begin
        r_crc <= reset ? '0 : o_next;
    end
endmodule

// File: rtl/crc_lane_engine.sv
// crc_lane_engine: CHANNELS lock-step CRC lanes with bit-count framing; either
// emits the CRC serially after the data or checks a received trailing CRC.
module crc_lane_engine
    import sd_crc_pkg::*;
#(
    parameter int LEN = 16,
    parameter logic [LEN:0] GEN = (LEN+1)'(LEN == 7 ? CRC7_GEN : CRC16_GEN),
    parameter int CHANNELS = 4,
    parameter logic [LEN-1:0] INIT = '0,
    parameter int CNT_W = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [CNT_W-1:0]         data_bits,
    input  logic                     in_valid,
    input  logic [CHANNELS-1:0]      in_bits,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CHANNELS-1:0]      out_bits,
    output logic                     busy,
    output logic                     done,
    output logic                     crc_ok,
    output logic [CHANNELS-1:0]      crc_err_lanes,
    output logic [CHANNELS*LEN-1:0]  crc_value
);
    localparam int TW = $clog2(LEN + 1);

    crc_state_t                r_state;
    logic                      r_mode;
    logic                      r_ok;
    logic [CNT_W-1:0]          r_cnt;
    logic [TW-1:0]             r_tcnt;
    logic [CHANNELS*LEN-1:0]   r_emit;
    logic [CHANNELS-1:0]       r_err;
    logic [CHANNELS*LEN-1:0]   w_next;
    logic [CHANNELS*LEN-1:0]   w_shift;
    logic [CHANNELS-1:0]       w_res;
    logic                      w_load;
    logic                      w_step;
    logic                      w_ship;
    logic                      w_adv;

    always_comb begin
        w_load        = r_state == IDLE && start;
        w_step        = in_valid && (r_state == DATA || (r_state == TAIL && r_mode));
        w_ship        = r_state == TAIL && !r_mode && out_ready;
        w_adv         = w_ship || (r_state == TAIL && r_mode && in_valid);
        out_valid     = r_state == TAIL && !r_mode;
        busy          = r_state != IDLE;
        done          = r_state == DONE;
        crc_ok        = r_ok;
        crc_err_lanes = r_err;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        crc_lane_lfsr #(.LEN(LEN), .POLY(GEN[LEN-1:0]), .INIT(INIT)) u_lfsr (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load),
            .i_step (w_step),
            .i_bit  (in_bits[i]),
            .o_crc  (crc_value[lane_lsb(i, LEN) +: LEN]),
            .o_next (w_next[lane_lsb(i, LEN) +: LEN])
        );
        always_comb begin
            w_shift[lane_lsb(i, LEN) +: LEN] = {r_emit[lane_lsb(i, LEN) +: LEN-1], 1'b0};
            w_res[i]    = |w_next[lane_lsb(i, LEN) +: LEN];
            out_bits[i] = out_valid & r_emit[lane_lsb(i, LEN) + LEN - 1];
        end
    end

    // The emit register captures the LFSR value being written on the edge that
    // enters TAIL, so the first CRC bit is presented in the first TAIL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_emit  <= '0;
            r_ok    <= 1'b0;
            r_err   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_mode  <= mode;
                    r_cnt   <= data_bits;
                    r_ok    <= 1'b0;
                    r_err   <= '0;
                    r_emit  <= w_next;
                    r_tcnt  <= TW'(LEN);
                    r_state <= data_bits == '0 ? TAIL : DATA;
                end
                DATA: if (in_valid) begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= TAIL;
                        r_emit  <= w_next;
                        r_tcnt  <= TW'(LEN);
                    end
                end
                TAIL: if (w_adv) begin
                    r_tcnt <= r_tcnt - 1'b1;
                    if (w_ship) r_emit <= w_shift;
                    if (r_tcnt == TW'(1)) begin
                        r_state <= DONE;
                        r_err   <= r_mode ? w_res : '0;
                        r_ok    <= !r_mode || w_res == '0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_lane_engine.sv
// tb_crc_lane_engine: directed CRC7 and 4-lane CRC16 frames with known SD
// reference values (CMD0 CRC7 0x4A, 512 bytes of 0xFF CRC16 0x7FA1).
module tb_crc_lane_engine;
    import sd_crc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_start = 1'b0, a_mode = 1'b0, a_v = 1'b0, a_r = 1'b0;
    logic [12:0] a_db = '0;
    logic [0:0]  a_in = '0;
    logic        a_ov, a_busy, a_done, a_ok;
    logic [0:0]  a_ob, a_err;
    logic [6:0]  a_crc;

    logic        b_start = 1'b0, b_mode = 1'b0, b_v = 1'b0, b_r = 1'b0;
    logic [12:0] b_db = '0;
    logic [3:0]  b_in = '0;
    logic        b_ov, b_busy, b_done, b_ok;
    logic [3:0]  b_ob, b_err;
    logic [63:0] b_crc;

    crc_lane_engine #(.LEN(7), .GEN(CRC7_GEN), .CHANNELS(1), .INIT('0), .CNT_W(13)) u_crc7 (
        .clk(clk), .reset(reset), .start(a_start), .mode(a_mode), .data_bits(a_db),
        .in_valid(a_v), .in_bits(a_in), .out_ready(a_r), .out_valid(a_ov), .out_bits(a_ob),
        .busy(a_busy), .done(a_done), .crc_ok(a_ok), .crc_err_lanes(a_err), .crc_value(a_crc)
    );

    crc_lane_engine #(.LEN(16), .GEN(CRC16_GEN), .CHANNELS(4), .INIT('0), .CNT_W(13)) u_crc16 (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .data_bits(b_db),
        .in_valid(b_v), .in_bits(b_in), .out_ready(b_r), .out_valid(b_ov), .out_bits(b_ob),
        .busy(b_busy), .done(b_done), .crc_ok(b_ok), .crc_err_lanes(b_err), .crc_value(b_crc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input logic [3:0] flip, input logic [3:0] exp_err);
        logic [15:0] c = 16'h7FA1;
        int early = 0;
        b_start = 1'b1; b_mode = 1'b1; b_db = 13'd4096;
        tick;
        b_start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            b_v  = 1'b1;
            b_in = 4'hF ^ (i == 100 ? flip : 4'h0);
            if (b_done) early++;
            tick;
        end
        for (int i = 15; i >= 0; i--) begin
            b_in = {4{c[i]}};
            if (b_ov || b_done) early++;
            tick;
        end
        b_v = 1'b0;
        check("chk_no_early_done_or_valid", early, 0);
        check("chk_done", b_done, 1);
        check("chk_err_lanes", b_err, exp_err);
        check("chk_ok", b_ok, exp_err == 4'h0);
        tick;
        check("chk_idle", b_busy, 0);
        check("chk_err_held", b_err, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] msg;
        logic [6:0]  e7;
        logic [15:0] e0, e3;
        int cyc, n, k, early;

        repeat (3) tick;
        reset = 1'b0;
        check("rst_busy", b_busy, 0);
        check("rst_out_valid", b_ov, 0);
        check("rst_out_bits", b_ob, 0);
        check("rst_done", b_done, 0);
        check("rst_crc_ok", b_ok, 0);
        check("rst_err", b_err, 0);
        check("rst_crc_value", b_crc, 0);
        check("rst_crc7_busy", a_busy, 0);

        // CRC7 over CMD0 with a stale beat on the start cycle
        msg = 40'h40_0000_0000;
        a_start = 1'b1; a_mode = 1'b0; a_db = 13'd40; a_v = 1'b1; a_in = 1'b1;
        tick;
        a_start = 1'b0;
        check("crc7_busy", a_busy, 1);
        check("crc7_stale_beat", a_crc, 0);
        for (int i = 39; i >= 0; i--) begin
            a_in = msg[i]; a_v = 1'b1;
            tick;
        end
        a_v = 1'b0;
        check("crc7_value", a_crc, 7'h4A);
        check("crc7_out_valid", a_ov, 1);
        e7 = '0; early = 0; a_r = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (a_done || !a_ov) early++;
            e7 = {e7[5:0], a_ob[0]};
            tick;
        end
        a_r = 1'b0;
        check("crc7_emit", e7, 7'h4A);
        check("crc7_emit_window", early, 0);
        check("crc7_done", a_done, 1);
        check("crc7_ok", a_ok, 1);
        tick;
        check("crc7_idle", a_busy, 0);
        check("crc7_done_pulse", a_done, 0);
        check("crc7_ok_held", a_ok, 1);

        // CRC16 generate with input gaps, a start while busy and 1010 ready
        b_start = 1'b1; b_mode = 1'b0; b_db = 13'd4096; b_in = 4'hF; b_v = 1'b0;
        tick;
        b_start = 1'b0;
        cyc = 0; n = 0; early = 0;
        while (n < 4096 && cyc < 20000) begin
            b_v = (cyc % 5) != 4;
            b_start = cyc == 100;
            b_db = 13'd5;
            if (b_v) n++;
            if (b_ov || b_done) early++;
            tick;
            cyc++;
        end
        b_v = 1'b0; b_start = 1'b0;
        check("gen16_data_window", early, 0);
        check("gen16_beats", n, 4096);
        check("gen16_busy", b_busy, 1);
        check("gen16_crc_value", b_crc, {4{16'h7FA1}});
        check("gen16_out_valid", b_ov, 1);
        k = 0; e0 = '0; e3 = '0; b_r = 1'b1;
        while (k < 16 && cyc < 30000) begin
            if (b_done) early++;
            if (b_r && b_ov) begin
                e0 = {e0[14:0], b_ob[0]};
                e3 = {e3[14:0], b_ob[3]};
                k++;
            end
            tick;
            cyc++;
            b_r = ~b_r;
        end
        b_r = 1'b0;
        check("gen16_emit_lane0", e0, 16'h7FA1);
        check("gen16_emit_lane3", e3, 16'h7FA1);
        check("gen16_no_early_done", early, 0);
        check("gen16_done", b_done, 1);
        check("gen16_crc_held", b_crc, {4{16'h7FA1}});
        tick;
        check("gen16_idle", b_busy, 0);
        check("gen16_ok", b_ok, 1);

        run_check(4'b0000, 4'b0000);
        run_check(4'b0100, 4'b0100);

        // Reset mid-DATA, then an empty frame emits INIT
        b_start = 1'b1; b_mode = 1'b0; b_db = 13'd50; b_in = 4'hA;
        tick;
        b_start = 1'b0; b_v = 1'b1;
        early = 0;
        repeat (10) begin
            if (b_done) early++;
            tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_mid_no_done", early + b_done, 0);
        check("rst_mid_busy", b_busy, 0);
        check("rst_mid_crc", b_crc, 0);
        b_start = 1'b1; b_db = 13'd0; b_in = 4'hF;
        tick;
        b_start = 1'b0;
        check("empty_out_valid", b_ov, 1);
        e0 = 16'hFFFF; early = 0; b_r = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (b_done || !b_ov) early++;
            e0 = {e0[14:0], b_ob[0]};
            tick;
        end
        b_r = 1'b0; b_v = 1'b0;
        check("empty_emit", e0, 16'h0000);
        check("empty_window", early, 0);
        check("empty_done", b_done, 1);
        tick;
        check("empty_idle", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
